audio_gain_apply: RTL and testbench
===================================

Name: audio_gain_apply

Overview:
- Applies the 8-bit switch-selected gain code to a stream of signed audio samples; this is the consumer side of the gain code.
- Gain format: unsigned Q1.7, so 0x80 = 1.0 and 0xE0 = 1.75.
- Ramps the working gain toward the target by a fixed step per accepted sample, so switch changes cause no zipper noise.
- Sits between the sample source and the DSP/output path, using a valid/ready stream on both sides.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- GAIN_W, 8, gain code width.
- FRAC_W, 7, fractional bits of the gain code.
- RAMP_STEP, 1, maximum change of the working gain per accepted sample (in LSBs).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- gain_target  in  GAIN_W  requested gain code; may change on any cycle.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  DATA_W  signed scaled, rounded and saturated sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- gain_cur  out  GAIN_W  working gain currently applied.
- ramp_busy  out  1  high while gain_cur != gain_target.

Behaviour:
- Reset (async, rst=1):
  - gain_cur=0, so the output starts muted and fades in.
  - FSM=IDLE, both pipeline valids=0.
  - out_valid=0, out_data=0, ramp_busy=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Handshakes:
  - Accept on in_valid&&in_ready.
  - Output transfer on out_valid&&out_ready.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Pipeline: 2 stages, with s1_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_adv; it is purely combinational from the state and out_ready.
  - Latency is 2 cycles from acceptance to out_valid when there is no backpressure.
  - Full throughput: 1 sample per cycle.
  - No sample is dropped or duplicated under any out_ready pattern.
- Stage 1 (multiply):
  - On acceptance, product = in_data * {1'b0,gain_cur}, width DATA_W+GAIN_W+1, signed.
  - The multiply uses gain_cur as it was before this cycle's ramp update.
- Stage 2 (round and saturate):
  - Add 2^(FRAC_W-1), arithmetic shift right by FRAC_W (round half toward +inf).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Ramp FSM:
  - States: IDLE, RAMP_UP, RAMP_DOWN.
  - Evaluated on the cycle of each accepted sample only; with no accepted sample, gain_cur holds.
  - gain_target > gain_cur: state RAMP_UP, gain_cur += min(RAMP_STEP, target-gain_cur).
  - gain_target < gain_cur: state RAMP_DOWN, gain_cur -= min(RAMP_STEP, gain_cur-target).
  - Equal: state IDLE, no change.
  - Never overshoots the target and never wraps.
- Boundary conditions:
  - Target change mid-ramp: direction is re-evaluated on the next accepted sample, and reversal is allowed immediately.
  - ramp_busy = (gain_cur != gain_target), combinational, so it reacts to target changes in the same cycle.
  - Simultaneous stage-2 output transfer and new input acceptance: both happen, with no bubble.
  - Reset mid-stream: in-flight samples are discarded, outputs return to reset values, and gain_cur restarts at 0.
- Unity gain 0x80 is exactly transparent: out = in for all inputs.

Test Plan:
- Reset then gain_target=0x80 held, feed 200 samples continuously with out_ready=1:
  - gain_cur steps 0,1,2,…,0x80.
  - Sample n is scaled by gain n until n=128, after which out_data equals in_data.
  - ramp_busy drops on the cycle gain_cur reaches 0x80.
- gain_cur at 0x80, inputs 1234, -1, -32768, 32767 -> same values out, 2 cycles after acceptance.
- gain 0xE0 (settled), inputs 32767, -32768, 1000, -3 -> out 32767 (sat), -32768 (sat), 1750, -5.
  - -3*224 = -672, plus 64 = -608, >>>7 = -5.
- gain 0x40, inputs -3 and 3 -> -1 and 2 (half rounds toward +inf).
- Backpressure: stream 20 samples with out_ready toggling per a pseudo-random pattern:
  - in_ready stalls correctly.
  - Output sequence is bit-exact against the model, with no drops or duplicates.
  - out_data is stable during stalls.
- Settled at 0x80, target switched to 0x60 then back to 0x80 after 10 samples:
  - gain_cur goes 0x80→0x76, then 0x77…0x80.
  - in_valid low for 50 cycles during the ramp leaves gain_cur unchanged.
- Assert rst mid-stream with 2 samples in flight:
  - out_valid falls immediately, gain_cur=0.
  - No stale sample appears after release.

Source files
------------

// File: rtl/audio_gain_apply.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// audio_gain_apply
//
// Scales a stream of signed audio samples by an 8-bit unsigned Q1.7 gain code
// (0x80 = 1.0). The working gain ramps toward the requested code by at most
// RAMP_STEP per accepted sample, so a switch change never causes zipper noise.
// After reset the working gain is 0, so the output fades in from mute.
//
// Datapath: two register stages.
//   stage 1 : product = in_data * {1'b0, gain_cur}  (uses gain before the
//             ramp update made in the same cycle)
//   stage 2 : add 2^(FRAC_W-1), arithmetic shift right FRAC_W (round half
//             toward +inf), saturate to the DATA_W signed range
//
// Handshake (valid/ready, both sides):
//   A word moves across an interface on a rising edge where valid && ready.
//   A producer holding valid keeps its data stable until the transfer.
//   ready may depend combinationally on downstream ready but never on the
//   same-side valid, so no combinational loop can form through the block.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   gain_target     requested gain code (may change on any cycle)
//   in_data/valid/ready    input sample stream
//   out_data/valid/ready   scaled, rounded, saturated output stream
//   gain_cur        working gain currently applied to new samples
//   ramp_busy       gain_cur != gain_target (combinational)
//   dbg_ramp_state  ramp FSM state: 0 IDLE, 1 RAMP_UP, 2 RAMP_DOWN
// -----------------------------------------------------------------------------
module audio_gain_apply #(
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 8,
    parameter int FRAC_W    = 7,
    parameter int RAMP_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic        [GAIN_W-1:0] gain_target,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [GAIN_W-1:0] gain_cur,
    output logic                     ramp_busy,
    output logic               [1:0] dbg_ramp_state
);

    // Product of a signed DATA_W sample and a zero-extended GAIN_W gain.
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    // One extra bit so adding the rounding constant can never overflow.
    localparam int SUM_W  = PROD_W + 1;

    localparam logic signed [SUM_W-1:0] RND_CONST =
        {{(SUM_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic                     s1_valid_q, s1_valid_d;
    logic signed [PROD_W-1:0] s1_prod_q,  s1_prod_d;
    logic                     s2_valid_q, s2_valid_d;
    logic signed [DATA_W-1:0] s2_data_q,  s2_data_d;
    logic        [GAIN_W-1:0] gain_cur_q, gain_cur_d;
    ramp_state_t              state_q,    state_d;

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic s1_adv;
    logic accept;

    // Stage 1 may hand its word to stage 2 when stage 2 is empty or is
    // itself draining this cycle; that is what allows full throughput.
    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;

    // ---------------------------------------------------------------------
    // Stage 1 multiply
    // ---------------------------------------------------------------------
    logic signed [PROD_W-1:0] mul_a;
    logic signed [PROD_W-1:0] mul_b;
    logic signed [PROD_W-1:0] product;

    always_comb begin
        mul_a   = PROD_W'(in_data);
        mul_b   = PROD_W'({1'b0, gain_cur_q});
        // PROD_W holds the full product exactly, so truncation loses nothing.
        product = mul_a * mul_b;
    end

    // ---------------------------------------------------------------------
    // Stage 2 round and saturate
    // ---------------------------------------------------------------------
    logic signed [SUM_W-1:0]  rnd_sum;
    logic signed [SUM_W-1:0]  rnd_shift;
    logic signed [DATA_W-1:0] sat_data;

    always_comb begin
        rnd_sum   = SUM_W'(s1_prod_q) + RND_CONST;
        // Arithmetic shift floors, so +half then floor rounds half upward.
        rnd_shift = rnd_sum >>> FRAC_W;
        if (rnd_shift > SAT_MAX) begin
            sat_data = SAT_MAX[DATA_W-1:0];
        end else if (rnd_shift < SAT_MIN) begin
            sat_data = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_data = rnd_shift[DATA_W-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Pipeline next state
    // ---------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;

        // Stage 2 only changes when it can advance, which keeps out_data
        // frozen while the consumer stalls.
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = sat_data;
            end
        end

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (accept) begin
                s1_prod_d = product;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    // ---------------------------------------------------------------------
    // Gain ramp FSM
    // Evaluated only on accepted samples, so the ramp rate is tied to the
    // sample rate and an idle stream leaves the gain untouched. Direction is
    // decided fresh each time, so a target change mid-ramp reverses at once.
    // ---------------------------------------------------------------------
    logic [GAIN_W-1:0] gain_diff;
    logic [GAIN_W-1:0] gain_step;

    always_comb begin
        gain_cur_d = gain_cur_q;
        state_d    = state_q;
        gain_diff  = '0;
        gain_step  = '0;

        if (accept) begin
            if (gain_target > gain_cur_q) begin
                gain_diff  = gain_target - gain_cur_q;
                // Clamping the step to the remaining distance prevents
                // overshoot and therefore any wrap of the unsigned gain.
                gain_step  = (gain_diff < STEP) ? gain_diff : STEP;
                gain_cur_d = gain_cur_q + gain_step;
                state_d    = RAMP_UP;
            end else if (gain_target < gain_cur_q) begin
                gain_diff  = gain_cur_q - gain_target;
                gain_step  = (gain_diff < STEP) ? gain_diff : STEP;
                gain_cur_d = gain_cur_q - gain_step;
                state_d    = RAMP_DOWN;
            end else begin
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_cur_q <= '0;
            state_q    <= IDLE;
        end else begin
            gain_cur_q <= gain_cur_d;
            state_q    <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign out_valid      = s2_valid_q;
    assign out_data       = s2_data_q;
    assign gain_cur       = gain_cur_q;
    assign dbg_ramp_state = state_q;
    // Held low during reset so the flag reads idle while the gain is forced.
    assign ramp_busy      = !rst && (gain_cur_q != gain_target);

endmodule

// File: tb/tb_audio_gain_apply.sv
`timescale 1ns/1ps
module tb_audio_gain_apply;

  localparam int DATA_W = 16;
  localparam int GAIN_W = 8;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic                     clk;
  logic                     rst;
  logic        [GAIN_W-1:0] gain_target;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic        [GAIN_W-1:0] gain_cur;
  logic                     ramp_busy;
  logic               [1:0] dbg_ramp_state;

  audio_gain_apply dut (
    .clk            (clk),
    .rst            (rst),
    .gain_target    (gain_target),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .gain_cur       (gain_cur),
    .ramp_busy      (ramp_busy),
    .dbg_ramp_state (dbg_ramp_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Counters and check helper
  // ---------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] exp_q[$];
  int                m_gain  = 0;
  int                m_state = 0;
  int                m_occ   = 0;
  bit                stall_prev = 0;
  int                held_data  = 0;

  function automatic int model_out(input int x, input int g);
    longint p;
    p = longint'(x) * longint'(g) + 64;
    p = p >>> 7;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return int'(p);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_gain     = 0;
      m_state    = 0;
      m_occ      = 0;
      stall_prev = 0;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_gain_cur", int'(gain_cur), 0);
      check("rst_ramp_busy", int'(ramp_busy), 0);
    end else begin
      check("in_ready", int'(in_ready), ((m_occ < 2) || out_ready) ? 1 : 0);
      check("gain_cur", int'(gain_cur), m_gain);
      check("ramp_state", int'(dbg_ramp_state), m_state);
      check("ramp_busy", int'(ramp_busy), (m_gain != int'(gain_target)) ? 1 : 0);
      if (stall_prev) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), held_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'(out_data), -99999);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          check("out_data", int'(out_data), int'($signed(e)));
        end
        m_occ--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(DATA_W'(model_out(int'(in_data), m_gain)));
        if (int'(gain_target) > m_gain) begin
          m_gain  = m_gain + 1;
          m_state = 1;
        end else if (int'(gain_target) < m_gain) begin
          m_gain  = m_gain - 1;
          m_state = 2;
        end else begin
          m_state = 0;
        end
        m_occ++;
      end
      stall_prev = out_valid && !out_ready;
      held_data  = int'(out_data);
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic drive_sample(input int d);
    bit acc;
    int tries;
    in_data  = DATA_W'(d);
    in_valid = 1'b1;
    acc      = 1'b0;
    tries    = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle(input logic [GAIN_W-1:0] g);
    int t;
    gain_target = g;
    t = 0;
    while (m_gain != int'(g) && t < 300) begin
      drive_sample(0);
      t++;
    end
    check("settle_gain", int'(gain_cur), int'(g));
    idle(3);
  endtask

  task automatic drain();
    int t;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(2);
  endtask

  // ---------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------
  typedef struct {
    logic [GAIN_W-1:0] gain;
    int                din;
    int                dout;
  } vec_t;

  vec_t vecs[14];
  bit   bp_done;
  logic [31:0] bp_pat;

  initial begin
    vecs[0]  = '{8'hE0,  32767,  32767};
    vecs[1]  = '{8'hE0, -32768, -32768};
    vecs[2]  = '{8'hE0,   1000,   1750};
    vecs[3]  = '{8'hE0,     -3,     -5};
    vecs[4]  = '{8'h40,     -3,     -1};
    vecs[5]  = '{8'h40,      3,      2};
    vecs[6]  = '{8'hFF,    100,    199};
    vecs[7]  = '{8'hFF,   -100,   -199};
    vecs[8]  = '{8'h00,  12345,      0};
    vecs[9]  = '{8'h80,   1234,   1234};
    vecs[10] = '{8'h80,     -1,     -1};
    vecs[11] = '{8'h80, -32768, -32768};
    vecs[12] = '{8'h80,  32767,  32767};
    vecs[13] = '{8'h80,      0,      0};

    rst         = 1'b0;
    gain_target = '0;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    bp_done     = 1'b0;
    bp_pat      = 32'hB5C3_9A4E;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("in_ready_after_reset", int'(in_ready), 1);
    check("gain_after_reset", int'(gain_cur), 0);

    // Fade-in ramp: 200 continuous samples at target 0x80.
    gain_target = 8'h80;
    #1;
    check("ramp_busy_start", int'(ramp_busy), 1);
    for (int n = 0; n < 200; n++) begin
      drive_sample((n * 257) - 20000);
      check("fade_gain", int'(gain_cur), (n + 1 < 128) ? n + 1 : 128);
      check("fade_busy", int'(ramp_busy), (n + 1 < 128) ? 1 : 0);
    end
    drain();

    // Table vectors: settle gain, apply one sample, check 2-cycle latency.
    for (int i = 0; i < 14; i++) begin
      settle(vecs[i].gain);
      drive_sample(vecs[i].din);
      check("vec_latency_early", int'(out_valid), 0);
      @(posedge clk);
      #1;
      check("vec_valid", int'(out_valid), 1);
      check("vec_data", int'(out_data), vecs[i].dout);
      drain();
    end

    // Mid-ramp reversal from settled 0x80.
    gain_target = 8'h60;
    #1;
    check("rev_busy_down", int'(ramp_busy), 1);
    for (int i = 0; i < 10; i++) begin
      drive_sample(i * 100 - 400);
      check("rev_down_gain", int'(gain_cur), 8'h80 - (i + 1));
      check("rev_down_state", int'(dbg_ramp_state), 2);
    end
    gain_target = 8'h80;
    #1;
    check("rev_busy_up", int'(ramp_busy), 1);
    for (int i = 0; i < 5; i++) begin
      drive_sample(i * 333);
      check("rev_up_gain", int'(gain_cur), 8'h77 + i);
      check("rev_up_state", int'(dbg_ramp_state), 1);
    end
    idle(50);
    check("idle_gain_hold", int'(gain_cur), 8'h7B);
    for (int i = 0; i < 5; i++) begin
      drive_sample(-i * 555);
      check("rev_up2_gain", int'(gain_cur), 8'h7C + i);
    end
    check("rev_done_busy", int'(ramp_busy), 0);
    drive_sample(77);
    check("rev_idle_gain", int'(gain_cur), 8'h80);
    check("rev_idle_state", int'(dbg_ramp_state), 0);
    drain();

    // Backpressure: 20 samples with a fixed out_ready pattern, gain ramping.
    gain_target = 8'h90;
    fork
      begin
        for (int i = 0; i < 20; i++) drive_sample((i * 3001) - 30000);
        bp_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!bp_done && k < 400) begin
          out_ready = bp_pat[k % 32];
          k++;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_gain_end", int'(gain_cur), 8'h90);

    // Reset with two samples in flight.
    drive_sample(111);
    drive_sample(222);
    check("inflight_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_gain", int'(gain_cur), 0);
    check("midrst_out_data", int'(out_data), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 10; i++) begin
      check("no_stale_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
    end
    check("post_rst_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
